// File: rtl/mc_control.sv
// Multicycle MIPS-subset main controller.
// Moore-style control decode of the registered state, with the FETCH
// load enables gated by memory readiness and the BRANCH PC load gated by
// the ALU zero flag. Also counts retired instructions.
module mc_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        write_pc,
  output logic [1:0]  pcsource,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic [2:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] count_reg;
  logic        retire;

  // With waiting disabled the memory is assumed to answer in one cycle.
  logic ready;
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Opcode classes; IR is stable from DECODE onward, so these are only
  // meaningful in DECODE and later states.
  logic is_lw, is_sw, is_r, is_beq, is_bne, is_j, is_jal;
  logic is_addi, is_andi, is_ori;
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_r    = (op == 6'b000000);
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_addi = (op == 6'b001000);
  assign is_andi = (op == 6'b001100);
  assign is_ori  = (op == 6'b001101);

  // R-type ALU function and funct legality.
  logic       funct_ok;
  logic [2:0] r_alu_op;
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b101010: r_alu_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  logic op_legal;
  assign op_legal = is_lw | is_sw | (is_r & funct_ok) | is_beq | is_bne |
                    is_j | is_jal | is_addi | is_andi | is_ori;

  // Logical immediates are zero-extended; addi is sign-extended.
  logic       imm_zext;
  logic [2:0] imm_alu_op;
  assign imm_zext   = is_andi | is_ori;
  assign imm_alu_op = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);

  // Next-state selection and retirement detection.
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!op_legal)             state_next = S_FETCH;
        else if (is_lw || is_sw)   state_next = S_MEMADR;
        else if (is_r)             state_next = S_EXEC;
        else if (is_beq || is_bne) state_next = S_BRANCH;
        else if (is_j || is_jal)   state_next = S_JUMP;
        else                       state_next = S_IEXEC;
      end
      S_MEMADR: state_next = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  retire = 1'b1;
      S_MEMWR: begin
        state_next = ready ? S_FETCH : S_MEMWR;
        retire     = ready;
      end
      S_EXEC:   state_next = S_RWB;
      S_RWB:    retire = 1'b1;
      S_BRANCH: retire = 1'b1;
      S_JUMP:   retire = 1'b1;
      S_IEXEC:  state_next = S_IWB;
      S_IWB:    retire = 1'b1;
      default:  state_next = S_FETCH;
    endcase
  end

  // State and retired-instruction counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (retire) count_reg <= count_reg + 32'd1;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

  // Per-state control decode; enables forced low while reset is held.
  always_comb begin
    write_pc   = 1'b0;
    pcsource   = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        write_pc  = ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pcsource  = 2'b01;
        write_pc  = is_beq ? zero : ~zero;
      end
      S_JUMP: begin
        pcsource = 2'b10;
        write_pc = 1'b1;
        if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op;
        ext_zero  = imm_zext;
      end
      S_IWB: begin
        reg_write = 1'b1;
        ext_zero  = imm_zext;
      end
      default: ;
    endcase
    if (rst) begin
      write_pc  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: each instruction is expanded into the
// cycle-by-cycle control sequence it should produce (including random
// memory waits) and compared against the DUT every cycle.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        write_pc, ir_write, mem_read, mem_write, iord, reg_write;
  logic        alu_src_a, ext_zero, illegal;
  logic [1:0]  pcsource, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  typedef struct packed {
    logic       write_pc;
    logic [1:0] pcsource;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  mc_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .write_pc(write_pc), .pcsource(pcsource),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  ctl_t obs_ctl;
  assign obs_ctl = {write_pc, pcsource, ir_write, mem_read, mem_write, iord,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                    ext_zero, alu_op, illegal};

  int n_cmp = 0;
  int n_bad = 0;
  int model_count = 0;
  int cycles;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply mem_ready, compare outputs mid-cycle, advance.
  task automatic step(input string tag, input logic [3:0] es,
                      input ctl_t ec, input logic rdy);
    mem_ready = rdy;
    #1;
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".ctl"},   32'(obs_ctl), 32'(ec));
    check({tag, ".count"}, instr_count, 32'(model_count));
    cycles++;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ctl_t fetch_ctl(input logic rdy);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.ir_write  = rdy;
    c.write_pc  = rdy;
    return c;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycle sequence and run it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fetch_waits);
    ctl_t       c;
    logic       legal;
    logic [2:0] rop;
    int         mw;
    op = o; funct = f; zero = z;
    cycles = 0;
    for (int i = 0; i < fetch_waits; i++) step("fetch_wait", 4'd0, fetch_ctl(1'b0), 1'b0);
    step("fetch", 4'd0, fetch_ctl(1'b1), 1'b1);

    legal = 1'b0;
    rop = 3'b000;
    case (o)
      6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0c, 6'h0d: legal = 1'b1;
      6'h00: begin
        legal = 1'b1;
        case (f)
          6'h20: rop = 3'b000;
          6'h22: rop = 3'b001;
          6'h24: rop = 3'b010;
          6'h25: rop = 3'b011;
          6'h2a: rop = 3'b100;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    c = '0; c.alu_src_b = 2'b11; c.illegal = ~legal;
    step("decode", 4'd1, c, rbit());
    if (!legal) begin
      $display("instr op=%b funct=%b illegal cycles=%0d count=%0d", o, f, cycles, model_count);
      return;
    end

    mw = $urandom_range(0, 2);
    case (o)
      6'h23, 6'h2b: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        step("memadr", 4'd2, c, rbit());
        c = '0; c.iord = 1'b1;
        if (o == 6'h23) begin
          c.mem_read = 1'b1;
          for (int i = 0; i < mw; i++) step("memrd_wait", 4'd3, c, 1'b0);
          step("memrd", 4'd3, c, 1'b1);
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
          step("memwb", 4'd4, c, rbit());
        end else begin
          c.mem_write = 1'b1;
          for (int i = 0; i < mw; i++) step("memwr_wait", 4'd5, c, 1'b0);
          step("memwr", 4'd5, c, 1'b1);
        end
      end
      6'h00: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = rop;
        step("exec", 4'd6, c, rbit());
        c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01;
        step("rwb", 4'd7, c, rbit());
      end
      6'h04, 6'h05: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pcsource = 2'b01;
        c.write_pc = (o == 6'h04) ? z : ~z;
        step("branch", 4'd8, c, rbit());
      end
      6'h02, 6'h03: begin
        c = '0; c.pcsource = 2'b10; c.write_pc = 1'b1;
        if (o == 6'h03) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        step("jump", 4'd9, c, rbit());
      end
      default: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op   = (o == 6'h0c) ? 3'b010 : ((o == 6'h0d) ? 3'b011 : 3'b000);
        c.ext_zero = (o != 6'h08);
        step("iexec", 4'd10, c, rbit());
        c = '0; c.reg_write = 1'b1; c.ext_zero = (o != 6'h08);
        step("iwb", 4'd11, c, rbit());
      end
    endcase
    model_count++;
    $display("instr op=%b funct=%b zero=%b cycles=%0d count=%0d", o, f, z, cycles, model_count);
  endtask

  // Random instruction mix, including illegal opcodes and functs.
  task automatic run_random(input int n);
    logic [5:0] ops [14];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03,
            6'h08, 6'h0c, 6'h0d, 6'h01, 6'h3f, 6'h10};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int k = 0; k < n; k++) begin
      o = ops[$urandom_range(0, 13)];
      f = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(o, f, rbit(), $urandom_range(0, 2));
    end
  endtask

  initial begin
    ctl_t c;
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = 6'h23; funct = 6'h20;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.enables", {27'd0, write_pc, ir_write, mem_read, mem_write, reg_write}, 32'd0);
    check("rst.state", 32'(state), 32'd0);
    check("rst.count", instr_count, 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: lw, FETCH wait of 3, beq/bne both ways, illegal funct, jal.
    run_instr(6'h23, 6'h00, 1'b0, 0);
    run_instr(6'h2b, 6'h00, 1'b0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0);
    run_instr(6'h05, 6'h00, 1'b0, 0);
    run_instr(6'h00, 6'h07, 1'b0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0);
    run_instr(6'h0d, 6'h00, 1'b0, 1);

    run_random(60);

    // Reset while lw is stalled in MEMRD.
    op = 6'h23; funct = 6'h00;
    step("rstmid.fetch", 4'd0, fetch_ctl(1'b1), 1'b1);
    c = '0; c.alu_src_b = 2'b11;
    step("rstmid.decode", 4'd1, c, 1'b1);
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    step("rstmid.memadr", 4'd2, c, 1'b1);
    c = '0; c.mem_read = 1'b1; c.iord = 1'b1;
    step("rstmid.memrd", 4'd3, c, 1'b0);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check("rstmid.mem_read", 32'(mem_read), 32'd0);
    check("rstmid.enables", {27'd0, write_pc, ir_write, mem_read, mem_write, reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_count = 0;
    #1;
    check("rstmid.state", 32'(state), 32'd0);
    check("rstmid.count", instr_count, 32'd0);
    $display("reset during memrd wait applied");
    @(negedge clk);

    run_random(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1, 1 = memory states stall until mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag; mem_ready  in  1  memory access completes this cycle.
REQ-005 write_pc  out  1  PC load enable; pcsource  out  2  00 ALU out, 01 C register, 10 jump address.
REQ-006 ir_write, mem_read, mem_write, iord, reg_write  out  1 each  datapath enables; iord 0 = PC address, 1 = C register address.
REQ-007 reg_dst  out  2  00 rt, 01 rd, 10 r31; mem_to_reg  out  2  00 C, 01 MDR, 10 PC.
REQ-008 alu_src_a  out  1  0 PC, 1 A; alu_src_b  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2; ext_zero  out  1  zero-extend imm.
REQ-009 alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-010 state  out  4  current state code; illegal  out  1  one-cycle pulse; instr_count  out  32  retired instructions.

Function
REQ-011 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11; codes 12-15 unreachable, SHALL go to FETCH.
REQ-012 Moore outputs except write_pc/ir_write gating below; any output not listed for a state is 0 (reg_dst, mem_to_reg, alu fields 0).
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op add, pcsource=00; ir_write=write_pc=mem_ready; advance to DECODE when mem_ready, else hold.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op add (branch target into C); next by op: 100011/101011 MEMADR, 000000 EXEC, 000100/000101 BRANCH, 000010/000011 JUMP, 001000/001100/001101 IEXEC.
REQ-015 Legal R funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct with op 000000, or unlisted op: illegal=1 in DECODE, next FETCH, no count.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, add; next MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD: mem_read=1, iord=1; hold until mem_ready, then MEMWB. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; next FETCH.
REQ-018 MEMWR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op per funct; next RWB. RWB: reg_write=1, reg_dst=01, mem_to_reg=00; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, sub, pcsource=01; write_pc=zero for beq, ~zero for bne; next FETCH.
REQ-021 JUMP: pcsource=10, write_pc=1; jal also reg_write=1, reg_dst=10, mem_to_reg=10; next FETCH.
REQ-022 IEXEC: alu_src_a=1, alu_src_b=10; addi add ext_zero=0, andi and ext_zero=1, ori or ext_zero=1; next IWB. IWB: reg_write=1, reg_dst=00, mem_to_reg=00, ext_zero held; next FETCH.
REQ-023 op/funct sampled only in DECODE and states after it; controller relies on IR stable between ir_write pulses.
REQ-024 instr_count increments by 1 (wrapping at 2^32) on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP, IWB.
REQ-025 Latencies with mem_ready=1: lw 5, sw/R/addi 4, beq/bne/j/jal 3 cycles.

Reset
REQ-026 rst sampled high: next state FETCH, instr_count 0, illegal 0; rst dominates all transitions, including mid-instruction and mem-wait.
REQ-027 While rst high, all enables (write_pc, ir_write, mem_read, mem_write, reg_write) SHALL be 0.

Verification
REQ-028 Reset, mem_ready=1, op=100011: states 0,1,2,3,4,0; reg_write only in state 4; instr_count=1.
REQ-029 FETCH with mem_ready low 3 cycles: state stays 0, write_pc=ir_write=0; high on 4th -> both pulse 1 cycle.
REQ-030 op=000100 zero=1 -> write_pc=1, pcsource=01 in BRANCH; zero=0 -> write_pc=0; bne inverse.
REQ-031 op=000000 funct=000111 -> illegal pulse in DECODE, back to FETCH, instr_count unchanged.
REQ-032 op=000011 -> JUMP: write_pc=1, pcsource=10, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-033 rst asserted in MEMRD while waiting -> next cycle state 0, instr_count 0, mem_read=0 during rst.
